// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register (load, shift, rotate,
// clear, hold under a clock enable) with a saturating shift counter that
// flags when a loaded word has been fully serialised.
// Optional build macro: UNIV_SHIFT_REG_PARITY_EN adds the registered even
// parity output par, tracking ^q.
module univ_shift_reg #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic [2:0]                 mode,
   input  logic [WIDTH-1:0]           x,
   input  logic                       sin_r,
   input  logic                       sin_l,
   output logic [WIDTH-1:0]           q,
   output logic                       sout_r,
   output logic                       sout_l,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       done
`ifdef UNIV_SHIFT_REG_PARITY_EN
   ,
   output logic                       par
`endif
);

   localparam int            CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_LOAD  = 3'b001;
   localparam logic [2:0] MODE_SHR   = 3'b010;
   localparam logic [2:0] MODE_SHL   = 3'b011;
   localparam logic [2:0] MODE_ROR   = 3'b100;
   localparam logic [2:0] MODE_ROL   = 3'b101;
   localparam logic [2:0] MODE_CLEAR = 3'b110;

   logic [WIDTH-1:0] q_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] q_next_s;
   logic [CW-1:0]    cnt_next_s;
   logic [CW-1:0]    cnt_inc_s;

   // Next-state selection for the data register and the shift counter.
   always_comb begin
      q_next_s   = q_r;
      cnt_next_s = cnt_r;
      // Counter saturates at WIDTH so done stays up until a load or clear.
      cnt_inc_s  = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
      case (mode)
         MODE_HOLD: begin
            q_next_s   = q_r;
            cnt_next_s = cnt_r;
         end
         MODE_LOAD: begin
            q_next_s   = x;
            cnt_next_s = {CW{1'b0}};
         end
         MODE_SHR: begin
            q_next_s   = {sin_r, q_r[WIDTH-1:1]};
            cnt_next_s = cnt_inc_s;
         end
         MODE_SHL: begin
            q_next_s   = {q_r[WIDTH-2:0], sin_l};
            cnt_next_s = cnt_inc_s;
         end
         MODE_ROR: begin
            q_next_s   = {q_r[0], q_r[WIDTH-1:1]};
            cnt_next_s = cnt_inc_s;
         end
         MODE_ROL: begin
            q_next_s   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            cnt_next_s = cnt_inc_s;
         end
         MODE_CLEAR: begin
            // Clear goes to all-zeros, deliberately not RESET_VAL.
            q_next_s   = {WIDTH{1'b0}};
            cnt_next_s = {CW{1'b0}};
         end
         default: begin
            // Reserved encoding behaves as hold.
            q_next_s   = q_r;
            cnt_next_s = cnt_r;
         end
      endcase
   end

   // Data and counter registers: async reset, update only when enabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_r   <= RESET_VAL;
         cnt_r <= {CW{1'b0}};
      end else if (en) begin
         q_r   <= q_next_s;
         cnt_r <= cnt_next_s;
      end
   end

   assign q      = q_r;
   assign cnt    = cnt_r;
   assign sout_r = q_r[0];
   assign sout_l = q_r[WIDTH-1];
   assign done   = (cnt_r == CNT_MAX);

`ifdef UNIV_SHIFT_REG_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   logic par_r;

   // Parity register written from the next-state word so it tracks q exactly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         par_r <= even_parity(RESET_VAL);
      end else if (en) begin
         par_r <= even_parity(q_next_s);
      end
   end

   assign par = par_r;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4, RESET_VAL=0) with an
// arithmetic reference model and directed plus randomized scenarios.
module tb_univ_shift_reg;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         en;
   logic [2:0]   mode;
   logic [W-1:0] x;
   logic         sin_r;
   logic         sin_l;
   logic [W-1:0] q;
   logic         sout_r;
   logic         sout_l;
   logic [2:0]   cnt;
   logic         done;
`ifdef UNIV_SHIFT_REG_PARITY_EN
   logic         par;
`endif

   int errors = 0;
   int checks = 0;

   // reference model state
   int m_q   = 0;
   int m_cnt = 0;

   univ_shift_reg #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .mode   (mode),
      .x      (x),
      .sin_r  (sin_r),
      .sin_l  (sin_l),
      .q      (q),
      .sout_r (sout_r),
      .sout_l (sout_l),
      .cnt    (cnt),
      .done   (done)
`ifdef UNIV_SHIFT_REG_PARITY_EN
      ,
      .par    (par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour from the mode table, written with integer arithmetic.
   task automatic model_step(input logic e, input logic [2:0] m, input int xx,
                             input logic sr, input logic sl);
      int full;
      full = 1 << W;
      if (e && reset) begin
         case (m)
            3'd1: begin m_q = xx; m_cnt = 0; end
            3'd2: begin m_q = (m_q / 2) + (sr ? full / 2 : 0); if (m_cnt < W) m_cnt++; end
            3'd3: begin m_q = (m_q * 2 + (sl ? 1 : 0)) % full; if (m_cnt < W) m_cnt++; end
            3'd4: begin m_q = (m_q / 2) + ((m_q % 2) * (full / 2)); if (m_cnt < W) m_cnt++; end
            3'd5: begin m_q = ((m_q * 2) % full) + (m_q / (full / 2)); if (m_cnt < W) m_cnt++; end
            3'd6: begin m_q = 0; m_cnt = 0; end
            default: ;
         endcase
      end
   endtask

   // Drive one cycle: inputs applied, rising edge, model advanced, settle 1 time unit.
   task automatic cycle(input logic e, input logic [2:0] m, input logic [W-1:0] xx,
                        input logic sr, input logic sl);
      en = e; mode = m; x = xx; sin_r = sr; sin_l = sl;
      @(posedge clk);
      model_step(e, m, int'(xx), sr, sl);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0; en = 1'b1; mode = 3'b001; x = 4'b1111; sin_r = 1'b1; sin_l = 1'b1;
      #2;
      checks++;
      if (q !== 4'b0000 || cnt !== 3'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state q=%b cnt=%0d done=%b required q=0000 cnt=0 done=0", q, cnt, done);
      end
      // Clock edges during reset must not load even with en=1, mode=load.
      @(posedge clk); #1;
      checks++;
      if (q !== 4'b0000 || cnt !== 3'd0) begin
         errors++;
         $display("FAIL reset_overrides q=%b cnt=%0d required q=0000 cnt=0", q, cnt);
      end
      @(negedge clk);
      reset = 1'b1;
      m_q = 0; m_cnt = 0;
   endtask

   task automatic test_load;
      cycle(1'b1, 3'b001, 4'b1011, 1'b0, 1'b0);
      checks++;
      if (q !== 4'b1011 || cnt !== 3'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL load q=%b cnt=%0d done=%b required q=1011 cnt=0 done=0", q, cnt, done);
      end
   endtask

   task automatic test_piso_shift_right;
      logic [W-1:0] exp_q [4];
      logic         exp_so [4];
      exp_q  = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
      exp_so = '{1'b1, 1'b1, 1'b0, 1'b1};
      cycle(1'b1, 3'b001, 4'b1011, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (sout_r !== exp_so[i]) begin
            errors++;
            $display("FAIL piso_sout_r step %0d got %b required %b", i, sout_r, exp_so[i]);
         end
         cycle(1'b1, 3'b010, 4'b0000, 1'b0, 1'b0);
         checks++;
         if (q !== exp_q[i] || int'(cnt) != i + 1 || done !== (i == 3)) begin
            errors++;
            $display("FAIL piso_shift step %0d q=%b cnt=%0d done=%b required q=%b cnt=%0d done=%b",
                     i, q, cnt, done, exp_q[i], i + 1, (i == 3));
         end
      end
      cycle(1'b1, 3'b010, 4'b0000, 1'b0, 1'b0);
      checks++;
      if (cnt !== 3'd4 || done !== 1'b1) begin
         errors++;
         $display("FAIL piso_saturate cnt=%0d done=%b required cnt=4 done=1", cnt, done);
      end
      cycle(1'b1, 3'b000, 4'b0000, 1'b0, 1'b0);
      checks++;
      if (done !== 1'b1 || q !== 4'b0000) begin
         errors++;
         $display("FAIL done_through_hold q=%b done=%b required q=0000 done=1", q, done);
      end
   endtask

   task automatic test_rotate_left;
      logic [W-1:0] exp_q [4];
      exp_q = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
      cycle(1'b1, 3'b001, 4'b1011, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 3'b101, 4'b0000, 1'b0, 1'b0);
         checks++;
         if (q !== exp_q[i] || done !== (i == 3)) begin
            errors++;
            $display("FAIL rotl step %0d q=%b done=%b required q=%b done=%b",
                     i, q, done, exp_q[i], (i == 3));
         end
      end
   endtask

   task automatic test_enable_hold_clear;
      cycle(1'b1, 3'b001, 4'b0111, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 3'b101, 4'b0000, 1'b0, 1'b0);
      checks++;
      if (q !== 4'b1011 || cnt !== 3'd3) begin
         errors++;
         $display("FAIL setup_q_cnt q=%b cnt=%0d required q=1011 cnt=3", q, cnt);
      end
      cycle(1'b0, 3'b001, 4'b0110, 1'b1, 1'b1);
      checks++;
      if (q !== 4'b1011 || cnt !== 3'd3) begin
         errors++;
         $display("FAIL en_low_hold q=%b cnt=%0d required q=1011 cnt=3", q, cnt);
      end
      cycle(1'b1, 3'b111, 4'b0110, 1'b1, 1'b1);
      checks++;
      if (q !== 4'b1011 || cnt !== 3'd3) begin
         errors++;
         $display("FAIL reserved_hold q=%b cnt=%0d required q=1011 cnt=3", q, cnt);
      end
      cycle(1'b1, 3'b110, 4'b0110, 1'b1, 1'b1);
      checks++;
      if (q !== 4'b0000 || cnt !== 3'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL clear q=%b cnt=%0d done=%b required q=0000 cnt=0 done=0", q, cnt, done);
      end
   endtask

   task automatic test_async_reset_mid;
      cycle(1'b1, 3'b001, 4'b1101, 1'b0, 1'b0);
      cycle(1'b1, 3'b010, 4'b0000, 1'b1, 1'b0);
      cycle(1'b1, 3'b010, 4'b0000, 1'b1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      m_q = 0; m_cnt = 0;
      checks++;
      if (q !== 4'b0000 || cnt !== 3'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_mid q=%b cnt=%0d done=%b required q=0000 cnt=0 done=0", q, cnt, done);
      end
      @(negedge clk);
      reset = 1'b1;
      // Fresh shift after reset counts from zero.
      cycle(1'b1, 3'b011, 4'b0000, 1'b0, 1'b1);
      checks++;
      if (q !== 4'b0001 || cnt !== 3'd1) begin
         errors++;
         $display("FAIL post_reset_shift q=%b cnt=%0d required q=0001 cnt=1", q, cnt);
      end
   endtask

`ifdef UNIV_SHIFT_REG_PARITY_EN
   task automatic test_parity;
      cycle(1'b1, 3'b001, 4'b1011, 1'b0, 1'b0);
      checks++;
      if (par !== 1'b1) begin
         errors++;
         $display("FAIL parity_load par=%b required 1", par);
      end
      cycle(1'b1, 3'b011, 4'b0000, 1'b0, 1'b0);
      checks++;
      if (q !== 4'b0110 || par !== 1'b0) begin
         errors++;
         $display("FAIL parity_shl q=%b par=%b required q=0110 par=0", q, par);
      end
   endtask
`endif

   task automatic test_random;
      logic [W-1:0] eq;
      logic [2:0]   ec;
      logic         pre_sr, pre_sl, exp_sr, exp_sl;
      for (int i = 0; i < 300; i++) begin
         // Weight toward shifts/rotates so done is reached often.
         logic [2:0] m;
         m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 5));
         pre_sr = sout_r;
         pre_sl = sout_l;
         exp_sr = 1'(m_q % 2);
         exp_sl = 1'(m_q / (1 << (W - 1)));
         checks++;
         if (pre_sr !== exp_sr || pre_sl !== exp_sl) begin
            errors++;
            $display("FAIL rand_sout iter %0d sout_r=%b sout_l=%b required %b %b",
                     i, pre_sr, pre_sl, exp_sr, exp_sl);
         end
         cycle(1'($urandom_range(0, 4) != 0), m, 4'($urandom), 1'($urandom), 1'($urandom));
         eq = 4'(m_q);
         ec = 3'(m_cnt);
         checks++;
         if (q !== eq || cnt !== ec || done !== (m_cnt == W)) begin
            errors++;
            $display("FAIL rand_state iter %0d q=%b cnt=%0d done=%b required q=%b cnt=%0d done=%b",
                     i, q, cnt, done, eq, ec, (m_cnt == W));
         end
`ifdef UNIV_SHIFT_REG_PARITY_EN
         checks++;
         if (par !== ^eq) begin
            errors++;
            $display("FAIL rand_parity iter %0d par=%b required %b", i, par, ^eq);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_piso_shift_right();
      test_rotate_left();
      test_enable_hold_clear();
      test_async_reset_mid();
`ifdef UNIV_SHIFT_REG_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register: the next generation of the team's fixed 4-bit PIPO buffer register.
- Supports parallel load, shift right/left with serial inputs, rotate right/left, synchronous clear and hold, all under a clock enable.
- Tracks the number of shifts since the last load and flags when a loaded word has been fully serialised.
- Used as the common register primitive for PIPO, SIPO, PISO and SISO datapaths.

Parameters:
- WIDTH, 4, register width in bits; legal range WIDTH >= 2.
- RESET_VAL, 0, value of q after reset; WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when 0, all state holds regardless of mode.
- mode  input  3  operation select (encoding under Behaviour).
- x  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering the MSB on shift right.
- sin_l  input  1  serial input entering the LSB on shift left.
- q  output  WIDTH  register contents.
- sout_r  output  1  q[0], combinational from q.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- cnt  output  $clog2(WIDTH+1)  shifts since the last load or clear; saturates at WIDTH.
- done  output  1  high when cnt == WIDTH; combinational from cnt.

Behaviour:
- Reset:
  - reset low forces q=RESET_VAL and cnt=0 immediately, without waiting for a clock edge; done=0 follows.
  - Reset overrides en and mode.
  - Deassertion takes effect at the next rising edge.
  - Reset asserted mid-serialisation abandons the transfer; no partial state is retained.
- All non-reset updates occur on a rising clk edge with en=1; latency is 1 cycle from inputs to q.
- mode encoding (en=1):
  - 000 hold: q and cnt unchanged.
  - 001 load: q <= x; cnt <= 0.
  - 010 shift right: q <= {sin_r, q[WIDTH-1:1]}; cnt increments.
  - 011 shift left: q <= {q[WIDTH-2:0], sin_l}; cnt increments.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}; cnt increments.
  - 101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; cnt increments.
  - 110 clear: q <= 0 (not RESET_VAL); cnt <= 0.
  - 111 reserved: behaves as hold.
- cnt rules:
  - "Increments" means cnt <= (cnt == WIDTH) ? WIDTH : cnt + 1; it never wraps.
  - After a load, done rises on the edge completing the WIDTH-th shift or rotate.
  - done stays high through further shifts and holds.
  - done drops only on load, clear or reset.
- Serial outputs:
  - sout_r and sout_l reflect the current q.
  - The bit shifted out on an edge is the value sout_r or sout_l presented just before that edge.
- Changing mode between shift and rotate without a load continues counting from the current cnt.

Optional Feature:
- Macro: UNIV_SHIFT_REG_PARITY_EN.
- Defined:
  - Adds output port par (1 bit), a registered even parity of q: par == ^q at all times after reset.
  - par is computed from the next-state value and written on the same edge as q.
  - par resets to ^RESET_VAL.
  - par holds when en=0.
- Undefined: port par is absent; no parity logic is present.

Test Plan:
- Async reset: WIDTH=4, RESET_VAL=0; drive reset=0 between clock edges -> q=0000, cnt=0, done=0 before the next edge.
- Load: x=1011, mode=001, en=1, one edge -> q=1011, cnt=0, done=0.
- PISO shift right: from q=1011, sin_r=0, mode=010, four edges:
  - q sequence 0101, 0010, 0001, 0000.
  - sout_r before each edge 1, 1, 0, 1.
  - cnt 1, 2, 3, 4; done=1 after the 4th edge.
  - A 5th edge keeps cnt=4 and done=1.
- Rotate left: from q=1011, mode=101, four edges -> q sequence 0111, 1110, 1101, 1011; done=1 after the 4th edge.
- Enable and hold:
  - en=0 with mode=001, x=0110 -> q and cnt unchanged.
  - en=1, mode=111 -> unchanged.
  - en=1, mode=110 from q=1011, cnt=3 -> q=0000, cnt=0.
- Parity (macro defined): load 1011 -> par=1; one shift left with sin_l=0 -> q=0110, par=0.
